// File: rtl/cdb_scheduler.sv
// Round-robin common-data-bus scheduler: grants one write-back request per cycle
// and registers the winning tag/result onto the CDB, with per-unit starvation flags.
module cdb_scheduler #(
  parameter int NREQ = 3,
  parameter int DW   = 64,
  parameter int TW   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cdb_hold,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*TW-1:0] req_tag,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              cdb_valid,
  output logic [TW-1:0]     cdb_id,
  output logic [DW-1:0]     cdb_data,
  output logic [NREQ-1:0]   starve
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(NREQ + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_next;
  logic          any_gnt;
  logic [TW-1:0] win_tag;
  logic [DW-1:0] win_data;
  logic [CW-1:0] wait_cnt [NREQ];
  logic [CW-1:0] cnt_next [NREQ];

  // Scan from rr_ptr with wrap; first requester found wins.
  always_comb begin : pick
    int unsigned idx;
    gnt     = '0;
    any_gnt = 1'b0;
    idx     = 0;
    if (!rst && !cdb_hold) begin
      for (int unsigned off = 0; off < NREQ; off++) begin
        idx = 32'(rr_ptr) + off;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!any_gnt && req[idx]) begin
          gnt[idx] = 1'b1;
          any_gnt  = 1'b1;
        end
      end
    end
  end

  // Winner mux is zero when nothing is granted, so the bus clears on idle edges.
  always_comb begin
    win_tag  = '0;
    win_data = '0;
    ptr_next = rr_ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_tag  = req_tag[i*TW +: TW];
        win_data = req_data[i*DW +: DW];
        ptr_next = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_next[i] = wait_cnt[i];
      if (gnt[i] || !req[i]) begin
        cnt_next[i] = '0;
      end else if (wait_cnt[i] != CW'(NREQ)) begin
        cnt_next[i] = wait_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_id    <= '0;
      cdb_data  <= '0;
      starve    <= '0;
      for (int unsigned i = 0; i < NREQ; i++) wait_cnt[i] <= '0;
    end else begin
      rr_ptr    <= ptr_next;
      cdb_valid <= any_gnt;
      cdb_id    <= win_tag;
      cdb_data  <= win_data;
      for (int unsigned i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= cnt_next[i];
        starve[i]   <= (cnt_next[i] >= CW'(NREQ));
      end
    end
  end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed bench for cdb_scheduler: reset, single request, contention, hold,
// wrap-around and request stability with hand-computed expectations.
module tb_cdb_scheduler;

  localparam int NREQ = 3;
  localparam int DW   = 64;
  localparam int TW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cdb_hold;
  logic [NREQ-1:0]   req;
  logic [NREQ*TW-1:0] req_tag;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_id;
  logic [DW-1:0]     cdb_data;
  logic [NREQ-1:0]   starve;

  int checks = 0;
  int errors = 0;
  int hits;

  cdb_scheduler #(.NREQ(NREQ), .DW(DW), .TW(TW)) dut (
    .clk(clk), .rst(rst), .cdb_hold(cdb_hold), .req(req),
    .req_tag(req_tag), .req_data(req_data), .gnt(gnt),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_data(cdb_data),
    .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; cdb_hold = 1'b0; req = '0; req_tag = '0; req_data = '0;
    tick();
    check("rst_valid", 64'(cdb_valid), 64'd0);
    check("rst_id", 64'(cdb_id), 64'd0);
    check("rst_data", cdb_data, 64'd0);
    check("rst_starve", 64'(starve), 64'd0);
    req = 3'b111;
    #1 check("rst_gnt", 64'(gnt), 64'd0);
    req = '0;
    rst = 1'b0;
    tick();

    // single adder request
    set_unit(1, 4'h5, 64'h10);
    req = 3'b010;
    #1 check("single_gnt", 64'(gnt), 64'b010);
    tick();
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_id", 64'(cdb_id), 64'h5);
    check("single_data", cdb_data, 64'h10);
    req = '0;
    tick();
    check("single_idle_valid", 64'(cdb_valid), 64'd0);
    check("single_idle_id", 64'(cdb_id), 64'd0);
    check("single_idle_data", cdb_data, 64'd0);

    // rr_ptr is now 2: unit 2 wins, then reset mid-run
    set_unit(0, 4'h1, 64'hA0);
    set_unit(1, 4'h2, 64'hB0);
    set_unit(2, 4'h3, 64'hC0);
    req = 3'b111;
    #1 check("pre_rst_gnt", 64'(gnt), 64'b100);
    tick();
    check("pre_rst_id", 64'(cdb_id), 64'h3);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(cdb_valid), 64'd0);
    check("async_rst_id", 64'(cdb_id), 64'd0);
    check("async_rst_gnt", 64'(gnt), 64'd0);
    tick();
    rst = 1'b0;

    // contention: 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("cont_gnt%0d", k), 64'(gnt), 64'(3'b001 << (k % 3)));
      tick();
      check($sformatf("cont_valid%0d", k), 64'(cdb_valid), 64'd1);
      check($sformatf("cont_id%0d", k), 64'((k % 3) + 1), 64'(cdb_id));
      check($sformatf("cont_data%0d", k), cdb_data, 64'hA0 + 64'(16 * (k % 3)));
      check($sformatf("cont_starve%0d", k), 64'(starve), 64'd0);
    end

    // clear counters, then hold with all requesting
    req = '0;
    tick();
    req = 3'b111;
    cdb_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1 check($sformatf("hold_gnt%0d", k), 64'(gnt), 64'd0);
      tick();
      check($sformatf("hold_valid%0d", k), 64'(cdb_valid), 64'd0);
      check($sformatf("hold_starve%0d", k), 64'(starve), (k >= 3) ? 64'b111 : 64'd0);
    end
    cdb_hold = 1'b0;
    #1 check("release_gnt", 64'(gnt), 64'b001);
    tick();
    check("release_id", 64'(cdb_id), 64'h1);
    check("release_starve", 64'(starve), 64'b110);

    // wrap-around: grant unit 1 so rr_ptr=2, then req=101
    #1 check("wrap_pre_gnt", 64'(gnt), 64'b010);
    tick();
    req = 3'b101;
    #1 check("wrap_gnt2", 64'(gnt), 64'b100);
    tick();
    check("wrap_id2", 64'(cdb_id), 64'h3);
    #1 check("wrap_gnt0", 64'(gnt), 64'b001);
    tick();
    check("wrap_id0", 64'(cdb_id), 64'h1);

    // move rr_ptr to 0 via a unit 2 grant, then stability scenario
    req = 3'b100;
    tick();
    req = '0;
    tick();
    set_unit(2, 4'h7, 64'hDEAD);
    req = 3'b111;
    hits = 0;
    #1 check("stab_gnt0", 64'(gnt), 64'b001);
    tick();
    check("stab_id0", 64'(cdb_id), 64'h1);
    req = 3'b110;
    #1 check("stab_gnt1", 64'(gnt), 64'b010);
    tick();
    check("stab_id1", 64'(cdb_id), 64'h2);
    req = 3'b100;
    #1 check("stab_gnt2", 64'(gnt), 64'b100);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) req = '0;
      if (cdb_valid && cdb_id == 4'h7 && cdb_data == 64'hDEAD) hits++;
    end
    check("stab_once", 64'(hits), 64'd1);
    check("stab_idle", 64'(cdb_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
